// File: rtl/led_effect_sequencer.sv
`default_nettype none
// ============================================================================
// led_effect_sequencer : four-effect, four-speed 8-LED pattern sequencer
// Revision 1.0 - initial release
// ============================================================================
module led_effect_sequencer #(
   parameter int BASE_DIV = 12_500_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       mode_tick,
   input  logic       speed_tick,
   input  logic       pause_tick,
   output logic [7:0] q,
   output logic [1:0] mode,
   output logic [1:0] speed,
   output logic       running
);

   localparam int CW = $clog2(BASE_DIV);

   localparam logic [1:0] MODE_COUNT  = 2'd0;
   localparam logic [1:0] MODE_RUN    = 2'd1;
   localparam logic [1:0] MODE_BOUNCE = 2'd2;
   localparam logic [1:0] MODE_FILL   = 2'd3;

   typedef enum logic {DIR_LEFT = 1'b0, DIR_RIGHT = 1'b1} dir_t;
   typedef enum logic {PH_FILL = 1'b0, PH_EMPTY = 1'b1} phase_t;

   logic [CW-1:0] cnt;
   logic [CW-1:0] period_m1;
   logic          step_due;
   logic [1:0]    mode_nxt;
   logic [7:0]    start_q;
   logic [7:0]    q_step;
   dir_t          dir, dir_nxt;
   phase_t        phase, phase_nxt;

   // BASE_DIV itself may not fit in CW bits, so subtract before narrowing
   assign period_m1 = CW'((BASE_DIV >> speed) - 1);
   assign step_due  = running && (cnt == period_m1);
   assign mode_nxt  = mode + 2'd1;
   assign start_q   = (mode_nxt == MODE_RUN || mode_nxt == MODE_BOUNCE) ? 8'h01 : 8'h00;

   always_comb begin
      q_step    = q;
      dir_nxt   = dir;
      phase_nxt = phase;
      case (mode)
         MODE_COUNT: q_step = q + 8'd1;
         MODE_RUN:   q_step = {q[6:0], q[7]};
         MODE_BOUNCE: begin
            if (dir == DIR_LEFT) begin
               q_step = {q[6:0], 1'b0};
               if (q[6]) dir_nxt = DIR_RIGHT;
            end else begin
               q_step = {1'b0, q[7:1]};
               if (q[1]) dir_nxt = DIR_LEFT;
            end
         end
         MODE_FILL: begin
            if (phase == PH_FILL) begin
               q_step = {q[6:0], 1'b1};
               if (q[6:0] == 7'h7F) phase_nxt = PH_EMPTY;
            end else begin
               q_step = {q[6:0], 1'b0};
               if (q[6:0] == 7'h00) phase_nxt = PH_FILL;
            end
         end
         default: q_step = q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         q       <= 8'h00;
         mode    <= MODE_COUNT;
         speed   <= 2'd0;
         running <= 1'b1;
         cnt     <= '0;
         dir     <= DIR_LEFT;
         phase   <= PH_FILL;
      end else begin
         if (pause_tick) running <= ~running;
         if (speed_tick) speed <= speed + 2'd1;

         // A mode reload or a speed change both discard any step due this cycle
         if (mode_tick) begin
            mode  <= mode_nxt;
            q     <= start_q;
            dir   <= DIR_LEFT;
            phase <= PH_FILL;
            cnt   <= '0;
         end else if (speed_tick) begin
            cnt <= '0;
         end else if (running) begin
            if (step_due) begin
               cnt   <= '0;
               q     <= q_step;
               dir   <= dir_nxt;
               phase <= phase_nxt;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_led_effect_sequencer.sv
`default_nettype none
// ============================================================================
// tb_led_effect_sequencer : directed + randomized bench with reference model
// Revision 1.0 - initial release
// ============================================================================
module tb_led_effect_sequencer;

   localparam int BASE = 8;

   logic       clk = 1'b0;
   logic       reset, mode_tick, speed_tick, pause_tick;
   logic [7:0] q;
   logic [1:0] mode, speed;
   logic       running;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model: effect position is a plain step index into each sequence
   int m_mode, m_speed, m_idx, m_el;
   bit m_run;

   logic [7:0] run_seq[8]     = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
   logic [7:0] bounce_seq[14] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                  8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
   logic [7:0] fill_seq[16]   = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                                  8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};

   led_effect_sequencer #(.BASE_DIV(BASE)) dut (
      .clk        (clk),
      .reset      (reset),
      .mode_tick  (mode_tick),
      .speed_tick (speed_tick),
      .pause_tick (pause_tick),
      .q          (q),
      .mode       (mode),
      .speed      (speed),
      .running    (running)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] pat(input int md, input int ix);
      int k;
      case (md)
         0: return 8'(ix % 256);
         1: return 8'(1 << (ix % 8));
         2: begin
            k = ix % 14;
            return 8'(1 << ((k <= 7) ? k : 14 - k));
         end
         default: begin
            k = ix % 16;
            if (k <= 8) return 8'((1 << k) - 1);
            return 8'((255 << (k - 8)) & 255);
         end
      endcase
   endfunction

   function automatic int period();
      return BASE >> m_speed;
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input bit rs, input bit mt, input bit st, input bit pt);
      bit due;
      if (rs) begin
         m_mode = 0; m_speed = 0; m_idx = 0; m_el = 0; m_run = 1;
      end else begin
         due = m_run && (m_el == period() - 1);
         if (mt) begin
            m_mode = (m_mode + 1) % 4; m_idx = 0; m_el = 0;
         end else if (st) begin
            m_el = 0;
         end else if (m_run) begin
            if (due) begin
               m_idx++; m_el = 0;
            end else begin
               m_el++;
            end
         end
         if (st) m_speed = (m_speed + 1) % 4;
         if (pt) m_run = !m_run;
      end
   endtask

   task automatic cycle(input bit rs = 0, input bit mt = 0, input bit st = 0, input bit pt = 0);
      reset = rs; mode_tick = mt; speed_tick = st; pause_tick = pt;
      @(posedge clk);
      model_edge(rs, mt, st, pt);
      #1;
      reset = 1'b0; mode_tick = 1'b0; speed_tick = 1'b0; pause_tick = 1'b0;
      chk("model_q",       q,                pat(m_mode, m_idx));
      chk("model_mode",    {6'd0, mode},     8'(m_mode));
      chk("model_speed",   {6'd0, speed},    8'(m_speed));
      chk("model_running", {7'd0, running},  {7'd0, m_run});
   endtask

   // advance until the next edge would take a step
   task automatic wait_due();
      int g = 0;
      while (!(m_run && m_el == period() - 1) && g < 64) begin
         cycle();
         g++;
      end
      chk("due_bound", 8'(g < 64), 8'd1);
   endtask

   initial begin
      int g;
      reset = 1'b1; mode_tick = 1'b0; speed_tick = 1'b0; pause_tick = 1'b0;
      m_mode = 0; m_speed = 0; m_idx = 0; m_el = 0; m_run = 1;

      cycle(1); cycle(1);
      chk("rst_q", q, 8'h00);
      chk("rst_running", {7'd0, running}, 8'd1);

      for (int s = 1; s <= 8; s++) begin
         repeat (7) cycle();
         chk("count_hold", q, 8'(s - 1));
         cycle();
         chk("count_step", q, 8'(s));
      end

      repeat (3) cycle(0, 0, 1);
      chk("speed3", {6'd0, speed}, 8'd3);
      g = 0;
      while (pat(m_mode, m_idx) != 8'hFF && g < 400) begin
         cycle();
         g++;
      end
      chk("count_ff", q, 8'hFF);
      cycle();
      chk("count_wrap", q, 8'h00);
      cycle(0, 0, 1);

      cycle(0, 1);
      chk("run_start", q, 8'h01);
      for (int i = 0; i < 8; i++) begin
         repeat (8) cycle();
         chk("run_seq", q, run_seq[i]);
      end

      cycle(0, 1);
      chk("bounce_start", q, 8'h01);
      for (int i = 0; i < 14; i++) begin
         repeat (8) cycle();
         chk("bounce_seq", q, bounce_seq[i]);
      end

      cycle(0, 1);
      chk("fill_start", q, 8'h00);
      for (int i = 0; i < 16; i++) begin
         repeat (8) cycle();
         chk("fill_seq", q, fill_seq[i]);
      end

      cycle(0, 0, 1); cycle(0, 0, 1);
      chk("speed2", {6'd0, speed}, 8'd2);
      cycle();
      chk("p2_hold", q, 8'h00);
      cycle();
      chk("p2_step", q, 8'h01);
      cycle(0, 0, 0, 1);
      chk("paused", {7'd0, running}, 8'd0);
      for (int i = 0; i < 20; i++) begin
         cycle();
         chk("pause_hold", q, 8'h01);
      end
      cycle(0, 0, 0, 1);
      chk("resume_run", {7'd0, running}, 8'd1);
      cycle();
      chk("resume_phase", q, 8'h03);
      cycle();
      cycle(0, 0, 0, 1);
      chk("pause_due_step", q, 8'h07);
      chk("pause_due_run", {7'd0, running}, 8'd0);
      cycle(0, 0, 0, 1);

      wait_due();
      cycle(0, 1);
      chk("coll_mode0", {6'd0, mode}, 8'd0);
      chk("coll_q0", q, 8'h00);
      wait_due();
      cycle(0, 1);
      chk("coll_q1", q, 8'h01);
      wait_due();
      cycle(0, 0, 1);
      chk("speed_discard", q, 8'h01);

      cycle(0, 1);
      repeat (10) cycle();
      cycle(1, 1, 1, 1);
      chk("mid_rst_q", q, 8'h00);
      chk("mid_rst_mode", {6'd0, mode}, 8'd0);
      chk("mid_rst_speed", {6'd0, speed}, 8'd0);
      chk("mid_rst_run", {7'd0, running}, 8'd1);

      for (int i = 0; i < 2000; i++) begin
         cycle($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0,
               $urandom_range(0, 29) == 0, $urandom_range(0, 24) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/led_effect_sequencer.md
# led_effect_sequencer

Controller that sequences the 8-LED pattern datapath. It consumes one-cycle tick pulses from the debounced front-panel buttons and selects one of four LED effects at one of four step rates, with pause/resume. It generates its own step enable from `clk` through an internal prescaler and drives the 8 LEDs from a registered output. It sits between the button debouncers and the LED pins, and replaces the direct button-clocked counter path.

## Interface
- `BASE_DIV`, default 12_500_000: step period in `clk` cycles at speed 0. Must be ≥ 8 and a multiple of 8.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `mode_tick`  input  1  one-cycle pulse from the debouncer; advances the effect.
- `speed_tick`  input  1  one-cycle pulse; advances the speed level.
- `pause_tick`  input  1  one-cycle pulse; toggles run/pause.
- `q`  output  8  LED pattern, registered.
- `mode`  output  2  current effect: 0 COUNT, 1 RUN, 2 BOUNCE, 3 FILL.
- `speed`  output  2  current speed level, 0..3.
- `running`  output  1  1 = stepping, 0 = paused.

## Operation
- **Reset values:** `q`=8'h00, `mode`=0, `speed`=0, `running`=1, prescaler `cnt`=0, BOUNCE direction=left, FILL phase=fill.
- **Step period:** P = BASE_DIV >> `speed` (BASE_DIV, /2, /4, /8).
- **Prescaler:**
  - When `running` and `cnt`==P-1: `cnt`←0 and one step is taken.
  - When `running` otherwise: `cnt`←`cnt`+1.
  - When paused: `cnt` and `q` hold.
  - Counter width is clog2(BASE_DIV).
- **Step rules per mode:**
  - COUNT: `q`←`q`+1 mod 256; 8'hFF wraps to 8'h00.
  - RUN: rotate left by 1; 8'h80 wraps to 8'h01.
  - BOUNCE: shift one position in the current direction.
    - Moving left from 8'h40 gives 8'h80, and direction becomes right.
    - Moving right from 8'h02 gives 8'h01, and direction becomes left.
    - Full sequence: 01,02,…,80,40,…,01, repeating. Each end pattern is shown for exactly one step.
  - FILL: two phases, 16 steps per cycle: 00,01,03,07,…,FF,FE,FC,…,80,00.
    - Fill phase: `q`←{`q`[6:0],1}. On reaching FF, switch to the empty phase.
    - Empty phase: `q`←{`q`[6:0],0}. On reaching 00, switch to the fill phase.
- **`mode_tick`:**
  - `mode`←`mode`+1, wrapping 3 to 0.
  - `q` reloads the new mode's start pattern: COUNT 00, RUN 01, BOUNCE 01 with direction left, FILL 00 with phase fill.
  - `cnt`←0. `running` is unchanged.
- **`speed_tick`:** `speed`←`speed`+1, wrapping 3 to 0; `cnt`←0; `q` unchanged.
- **`pause_tick`:** `running`←~`running`. `cnt` and `q` are unchanged.
- **Simultaneous events:** all ticks asserted in the same cycle each take effect in that cycle.
  - `mode_tick` reload takes priority over a step due in the same cycle; the step is discarded.
  - `speed_tick` clearing `cnt` also discards a coincident step.
  - `pause_tick` together with a due step: the step is taken using the pre-toggle `running` value.
- **Reset mid-operation:** any state returns to the reset values on the next edge; ticks in a reset cycle are ignored.
- Tick inputs are assumed to be single-cycle pulses. A held-high input acts once per cycle; no edge detection is performed here.

## Timing
- All outputs are registered and change only on a `clk` rising edge.
- A tick sampled at edge N is reflected on `mode`/`speed`/`running`/`q` after edge N.
- **First step after reset release:** with `reset` low from edge 0, `q` first changes after edge P, i.e. P cycles later.
- **After a `mode_tick` or `speed_tick` at edge N:** the next step occurs at edge N+P, using the new P.
- **Resume after a pause:** `cnt` continues from its held value. The remaining time to the next step equals the time that was remaining at pause.
- **Latency:** tick to output is 1 cycle. There is no handshake.

## Test plan
- Use BASE_DIV=8 for all scenarios.
- **Reset, COUNT:** release reset, run 8×8 cycles → `q` steps 00→01→…→08, one step every 8 cycles; first change at cycle 8.
- **COUNT wrap:** preset `q` to FF by running 255 steps at speed 3 (P=1), then one more step → `q`=00.
- **RUN then BOUNCE:** one `mode_tick` → `q`=01; 8 steps → 02,04,…,80,01. Second `mode_tick` → `q`=01; 14 steps → 02,…,80,40,…,01.
- **FILL:** third `mode_tick` → `q`=00; 16 steps → 01,03,07,0F,1F,3F,7F,FF,FE,FC,F8,F0,E0,C0,80,00.
- **Speed and pause:** `speed_tick` ×2 → `speed`=2, steps every 2 cycles. `pause_tick` → `running`=0 and `q` frozen for 20 cycles. `pause_tick` again → stepping resumes at the preserved phase.
- **Collision:**
  - `mode_tick` on the cycle `cnt`==P-1 → `mode` advances, `q` = start pattern, no step taken.
  - `reset` asserted mid-BOUNCE → `q`=00, `mode`=0, `speed`=0, `running`=1 next cycle.
